// File: rtl/alu_issue_if.sv
// alu_issue_if -- bundles the request, ALU-side and result signals of the
// ALU issue stage.
//   slave  : view used by the issue stage itself
//   master : view used by whatever drives requests, models the ALU and
//            consumes results
// Signals:
//   in_valid/in_ready, in_a, in_b, in_aluctrl, in_fctrl, in_dest : request
//   aip1, aip2, aluctrl, fctrl : operands/controls held towards the ALU
//   aop                        : registered ALU result
//   out_valid/out_ready, out_result, out_dest, out_zero, out_neg : result
//   busy                       : stage holds an operation
interface alu_issue_if #(
    parameter int DEST_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_a;
    logic [15:0]       in_b;
    logic [3:0]        in_aluctrl;
    logic [1:0]        in_fctrl;
    logic [DEST_W-1:0] in_dest;

    logic [15:0]       aip1;
    logic [15:0]       aip2;
    logic [3:0]        aluctrl;
    logic [1:0]        fctrl;
    logic [15:0]       aop;

    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_result;
    logic [DEST_W-1:0] out_dest;
    logic              out_zero;
    logic              out_neg;
    logic              busy;

    modport slave (
        input  in_valid, in_a, in_b, in_aluctrl, in_fctrl, in_dest,
        input  aop, out_ready,
        output in_ready, aip1, aip2, aluctrl, fctrl,
        output out_valid, out_result, out_dest, out_zero, out_neg, busy
    );

    modport master (
        output in_valid, in_a, in_b, in_aluctrl, in_fctrl, in_dest,
        output aop, out_ready,
        input  in_ready, aip1, aip2, aluctrl, fctrl,
        input  out_valid, out_result, out_dest, out_zero, out_neg, busy
    );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage -- accepts one ALU operation at a time, holds its operands
// on the ALU inputs while the external (registered) ALU evaluates it, then
// captures the ALU result with zero/negative flags and offers it downstream
// until it is taken.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, aborts any operation in flight
//   bus  : alu_issue_if.slave (request, ALU operands/result, result handshake)
// Sequence: IDLE --accept--> EXEC --> WAIT --> DONE --out_ready--> IDLE.
module alu_issue_stage #(
    parameter int DEST_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    alu_issue_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic accept;

    // accept-stage registers: operands and controls of the op in flight
    logic [15:0]       a_p0;
    logic [15:0]       b_p0;
    logic [3:0]        aluctrl_p0;
    logic [1:0]        fctrl_p0;
    logic [DEST_W-1:0] dest_p0;

    // result-stage registers: captured ALU output and flags
    logic [15:0]       result_p2;
    logic              zero_p2;
    logic              neg_p2;

    assign accept = bus.in_valid && (state == IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid) state_nxt = EXEC;
            EXEC: state_nxt = WAIT;
            WAIT: state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- accept boundary: operands only change when a new op is taken,
    // so they stay constant on the ALU inputs through EXEC, WAIT and DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_p0       <= '0;
            b_p0       <= '0;
            aluctrl_p0 <= '0;
            fctrl_p0   <= '0;
            dest_p0    <= '0;
        end else if (accept) begin
            a_p0       <= bus.in_a;
            b_p0       <= bus.in_b;
            aluctrl_p0 <= bus.in_aluctrl;
            fctrl_p0   <= bus.in_fctrl;
            dest_p0    <= bus.in_dest;
        end
    end

    // ---- WAIT->DONE boundary: the ALU registered its result on the
    // EXEC->WAIT edge, so aop is valid throughout WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_p2 <= '0;
            zero_p2   <= 1'b0;
            neg_p2    <= 1'b0;
        end else if (state == WAIT) begin
            result_p2 <= bus.aop;
            zero_p2   <= (bus.aop == 16'h0000);
            neg_p2    <= bus.aop[15];
        end
    end

    assign bus.aip1       = a_p0;
    assign bus.aip2       = b_p0;
    assign bus.aluctrl    = aluctrl_p0;
    assign bus.fctrl      = fctrl_p0;

    // The tag register is untouched until the next accept, which cannot
    // happen before DONE is left, so it doubles as the result tag.
    assign bus.out_dest   = dest_p0;
    assign bus.out_result = result_p2;
    assign bus.out_zero   = zero_p2;
    assign bus.out_neg    = neg_p2;

    // Decoded straight from state so an asynchronous reset drops them at once.
    assign bus.in_ready   = (state == IDLE);
    assign bus.out_valid  = (state == DONE);
    assign bus.busy       = (state != IDLE);

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter DEST_W, default 3: width of destination-register tag carried alongside each operation.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 in_valid  input  1  upstream operation request valid.
REQ-005 in_ready  output  1  stage can accept a request this cycle.
REQ-006 in_a, in_b  input  16 each  operand A / operand B.
REQ-007 in_aluctrl  input  4  ALU operation select.
REQ-008 in_fctrl  input  2  ALU shift-function select.
REQ-009 in_dest  input  DEST_W  destination tag.
REQ-010 aip1, aip2  output  16 each  operands driven to ALU.
REQ-011 aluctrl  output  4; fctrl  output  2  controls driven to ALU.
REQ-012 aop  input  16  ALU result.
REQ-013 out_valid  output  1  result available downstream.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 out_result  output  16; out_dest  output  DEST_W; out_zero  output  1; out_neg  output  1.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, EXEC, WAIT, DONE; encoding free.
REQ-018 in_ready SHALL be 1 only in IDLE; no acceptance in any other state.
REQ-019 Accept = in_valid & in_ready at a rising edge: latch in_a, in_b, in_aluctrl, in_fctrl, in_dest into operand registers; go IDLE->EXEC.
REQ-020 aip1/aip2/aluctrl/fctrl SHALL be driven from the operand registers and held constant from the accept edge until DONE exits.
REQ-021 EXEC->WAIT unconditionally on next edge (ALU registers its internal result on this edge).
REQ-022 WAIT->DONE on next edge; on this edge capture aop into out_result, compute out_zero = (aop == 0), out_neg = aop[15].
REQ-023 out_valid SHALL be 1 exactly in DONE; latency accept edge to out_valid high = 3 rising edges.
REQ-024 DONE: out_result, out_dest, out_zero, out_neg held stable while out_valid & ~out_ready.
REQ-025 DONE->IDLE on edge where out_ready = 1; out_valid falls after that edge; next accept possible the following edge (throughput 1 op per 4 cycles min).
REQ-026 out_ready ignored outside DONE; in_valid ignored outside IDLE.
REQ-027 No arithmetic performed in this stage; result width 16, no carry/overflow reporting.
REQ-028 busy = (state != IDLE).

Reset
REQ-029 rst high SHALL immediately force state IDLE, regardless of clock.
REQ-030 Reset values: out_valid 0, in_ready 1 (after deassertion), busy 0, out_result 0, out_dest 0, out_zero 0, out_neg 0, operand registers and aip1/aip2/aluctrl/fctrl 0.
REQ-031 Reset during EXEC/WAIT/DONE SHALL abort the operation; no out_valid for it after reset release.

Verification
REQ-032 Add: accept a=16'h0003, b=16'h0004, aluctrl=0 -> out_valid on 3rd edge, out_result 16'h0007, zero 0, neg 0.
REQ-033 Sub to zero: a=b=16'h1234, aluctrl=4'b0100 -> out_result 0, out_zero 1, out_neg 0.
REQ-034 Backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready 0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-035 Negative result: a=16'h0001, b=16'h0002, subtract -> out_result 16'hFFFF, out_neg 1.
REQ-036 Reset mid-WAIT: assert rst between edges -> state IDLE, out_valid 0 immediately, no result emitted after release.
REQ-037 Back-to-back: in_valid held high with two ops -> second accepted only on edge after DONE->IDLE; out_dest tags in order.
